// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source: period/high-time/burst settings are captured at start
// and held for the whole run; busy/done let a controller sequence back-to-back runs.
module pulse_train_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high_len,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [CNT_W-1:0] r_pcnt;
    logic [WIDTH-1:0] r_pm1;
    logic [WIDTH-1:0] r_hm1;
    logic [CNT_W-1:0] r_n;
    logic             r_mode;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_pm1;
    logic [WIDTH-1:0] w_hm1;
    logic [CNT_W-1:0] w_n;
    logic             w_accept;

    // Settings are stored minus one and clamped so the high phase always leaves a low cycle.
    assign w_pm1    = (i_period == '0) ? WIDTH'(1) : i_period;
    assign w_hm1    = (i_high_len < w_pm1) ? i_high_len : w_pm1 - WIDTH'(1);
    assign w_n      = (i_burst_cnt == '0) ? CNT_W'(1) : i_burst_cnt;
    assign w_accept = i_start && !i_stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_pm1   <= '0;
            r_hm1   <= '0;
            r_n     <= '0;
            r_mode  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_pcnt  <= '0;
                        r_pm1   <= w_pm1;
                        r_hm1   <= w_hm1;
                        r_n     <= w_n;
                        r_mode  <= i_mode;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_HIGH: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_pcnt  <= '0;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                        if (r_cnt == r_hm1) begin
                            r_state <= S_LOW;
                            r_pulse <= 1'b0;
                        end
                    end
                end
                S_LOW: begin
                    // r_cnt runs across the whole period, so r_pm1 marks its last low cycle.
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_pcnt  <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == r_pm1) begin
                        r_cnt <= '0;
                        if (r_mode && (r_pcnt == r_n - CNT_W'(1))) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_HIGH;
                            r_pulse <= 1'b1;
                            if (r_mode) begin
                                r_pcnt <= r_pcnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: constant vector table, corner-case sequences and a
// randomized run checked against an arithmetic model of the pulse timeline.
module tb_pulse_train_generator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic [WIDTH-1:0] highLen = '0;
    logic [CNT_W-1:0] burstCnt = '0;
    logic             pulse;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit mRun = 1'b0;
    bit mMode = 1'b0;
    int mT = 0;
    int mStop = 0;
    int mP = 2;
    int mH = 1;
    int mN = 1;

    typedef struct {
        bit mode;
        int period;
        int highLen;
        int burst;
        int off;
        bit p;
        bit b;
        bit d;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pulse_train_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode      (mode),
        .i_period    (period),
        .i_high_len  (highLen),
        .i_burst_cnt (burstCnt),
        .o_pulse     (pulse),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Expected outputs of cycle c, from the run's start edge, period P, high time H and burst size N.
    function automatic void modelOut(input int c, output logic p, output logic b, output logic d);
        int o;
        p = 1'b0;
        b = 1'b0;
        d = 1'b0;
        o = c - mT;
        if (!mRun || o < 1 || c > mStop) return;
        if (!mMode || o <= mN * mP) begin
            b = 1'b1;
            p = (((o - 1) % mP) < mH);
        end else if (o == mN * mP + 1) begin
            d = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic eP, input logic eB, input logic eD);
        checks++;
        if (pulse !== eP || busy !== eB || done !== eD) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: pulse/busy/done got %b%b%b expected %b%b%b",
                     name, cyc, pulse, busy, done, eP, eB, eD);
        end
    endtask

    task automatic tick(input string name);
        logic p, b, d;
        modelOut(cyc, p, b, d);
        @(posedge clk);
        if (!rstN) begin
            mRun = 1'b0;
        end else if (b && stop) begin
            mStop = cyc;
        end else if (!b && start && !stop) begin
            mRun  = 1'b1;
            mT    = cyc;
            mStop = 32'h7fff_ffff;
            mMode = mode;
            mP    = ((period == '0) ? 1 : int'(period)) + 1;
            mH    = (int'(highLen) + 1 < mP - 1) ? int'(highLen) + 1 : mP - 1;
            mN    = (burstCnt == '0) ? 1 : int'(burstCnt);
        end
        cyc++;
        #1;
        modelOut(cyc, p, b, d);
        checkOutput(name, p, b, d);
    endtask

    task automatic resetDut();
        rstN  = 1'b0;
        mRun  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        tick("reset");
        rstN = 1'b1;
    endtask

    task automatic applyStimulus(input bit m, input int per, input int hl, input int bc, output int t);
        mode     = m;
        period   = WIDTH'(per);
        highLen  = WIDTH'(hl);
        burstCnt = CNT_W'(bc);
        start    = 1'b1;
        t        = cyc;
        tick("start");
        start = 1'b0;
    endtask

    task automatic runTo(input int target, input string name);
        while (cyc < target) tick(name);
    endtask

    task automatic addVec(input bit m, input int per, input int hl, input int bc, input int off,
                          input bit p, input bit b, input bit d);
        vec_t v;
        v.mode = m; v.period = per; v.highLen = hl; v.burst = bc;
        v.off = off; v.p = p; v.b = b; v.d = d;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int t;

        addVec(0, 10, 0, 0, 1, 1, 1, 0);
        addVec(0, 10, 0, 0, 2, 0, 1, 0);
        addVec(0, 10, 0, 0, 12, 1, 1, 0);
        addVec(0, 10, 0, 0, 13, 0, 1, 0);
        addVec(0, 10, 0, 0, 23, 1, 1, 0);
        addVec(1, 4, 1, 3, 1, 1, 1, 0);
        addVec(1, 4, 1, 3, 2, 1, 1, 0);
        addVec(1, 4, 1, 3, 3, 0, 1, 0);
        addVec(1, 4, 1, 3, 6, 1, 1, 0);
        addVec(1, 4, 1, 3, 11, 1, 1, 0);
        addVec(1, 4, 1, 3, 12, 1, 1, 0);
        addVec(1, 4, 1, 3, 13, 0, 1, 0);
        addVec(1, 4, 1, 3, 15, 0, 1, 0);
        addVec(1, 4, 1, 3, 16, 0, 0, 1);
        addVec(1, 4, 1, 3, 17, 0, 0, 0);
        addVec(0, 3, 7, 0, 3, 1, 1, 0);
        addVec(0, 3, 7, 0, 4, 0, 1, 0);
        addVec(0, 3, 7, 0, 5, 1, 1, 0);
        addVec(0, 3, 7, 0, 8, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 1, 1, 0);
        addVec(0, 0, 0, 0, 2, 0, 1, 0);
        addVec(0, 0, 0, 0, 3, 1, 1, 0);
        addVec(1, 2, 0, 0, 1, 1, 1, 0);
        addVec(1, 2, 0, 0, 2, 0, 1, 0);
        addVec(1, 2, 0, 0, 3, 0, 1, 0);
        addVec(1, 2, 0, 0, 4, 0, 0, 1);
        addVec(1, 2, 0, 0, 5, 0, 0, 0);

        #12;
        checkOutput("reset state", 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;
        tick("idle");
        checkOutput("idle after reset", 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            resetDut();
            applyStimulus(vecs[i].mode, vecs[i].period, vecs[i].highLen, vecs[i].burst, t);
            runTo(t + vecs[i].off, "vector model");
            checkOutput($sformatf("vector %0d", i), vecs[i].p, vecs[i].b, vecs[i].d);
        end

        // Asynchronous reset in the middle of a cycle, mid-run.
        resetDut();
        applyStimulus(0, 5, 2, 0, t);
        runTo(t + 2, "pre-reset");
        #2;
        rstN = 1'b0;
        mRun = 1'b0;
        #1;
        checkOutput("async reset", 1'b0, 1'b0, 1'b0);
        tick("in reset");
        rstN = 1'b1;
        tick("post reset");
        tick("post reset");
        checkOutput("idle after release", 1'b0, 1'b0, 1'b0);

        resetDut();
        applyStimulus(0, 10, 0, 0, t);
        runTo(t + 25, "continuous");
        stop = 1'b1;
        tick("stop");
        stop = 1'b0;
        checkOutput("stop result", 1'b0, 1'b0, 1'b0);

        // Mid-run start and setting changes must not disturb the captured burst.
        resetDut();
        applyStimulus(1, 4, 1, 3, t);
        runTo(t + 3, "ignored inputs");
        start = 1'b1; period = 8'd0; highLen = 8'd6; mode = 1'b0; burstCnt = 8'd9;
        runTo(t + 6, "ignored inputs");
        checkOutput("ignored pulse 2", 1'b1, 1'b1, 1'b0);
        runTo(t + 12, "ignored inputs");
        checkOutput("ignored pulse 3", 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        runTo(t + 16, "ignored inputs");
        checkOutput("ignored done", 1'b0, 1'b0, 1'b1);

        resetDut();
        start = 1'b1;
        stop  = 1'b1;
        tick("start+stop");
        checkOutput("start+stop idle", 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;

        resetDut();
        mode = 1'b1; period = 8'd2; highLen = 8'd0; burstCnt = 8'd2;
        start = 1'b1;
        t = cyc;
        runTo(t + 7, "held start");
        checkOutput("fin with start held", 1'b0, 1'b0, 1'b1);
        tick("held start");
        checkOutput("back-to-back pulse", 1'b1, 1'b1, 1'b0);
        start = 1'b0;

        resetDut();
        applyStimulus(1, 3, 0, 5, t);
        runTo(t + 6, "mid-burst");
        #2;
        rstN = 1'b0;
        mRun = 1'b0;
        #1;
        checkOutput("reset mid-burst", 1'b0, 1'b0, 1'b0);
        tick("in reset");
        rstN = 1'b1;
        tick("post reset");
        applyStimulus(1, 2, 0, 2, t);
        checkOutput("restart pulse 1", 1'b1, 1'b1, 1'b0);
        runTo(t + 2, "restart");
        checkOutput("restart low", 1'b0, 1'b1, 1'b0);
        runTo(t + 4, "restart");
        checkOutput("restart pulse 2", 1'b1, 1'b1, 1'b0);
        runTo(t + 7, "restart");
        checkOutput("restart done", 1'b0, 1'b0, 1'b1);

        resetDut();
        for (int i = 0; i < 2500; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 40) == 0);
            mode     = 1'($urandom_range(0, 1));
            period   = WIDTH'($urandom_range(0, 6));
            highLen  = WIDTH'($urandom_range(0, 7));
            burstCnt = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                resetDut();
            end else begin
                tick("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
